// File: rtl/inst_sram_axi_bridge.sv
// Bridges the fetch stage's SRAM-like instruction port onto AXI4 AR/R channels (single-beat, in order).
// Optional macro INST_BRIDGE_RESP_ERR_EN adds a sticky inst_bus_err flag and zeroes errored read data.
module inst_sram_axi_bridge #(
  parameter logic [3:0] ARID_VAL        = 4'd0,
  parameter int         MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef INST_BRIDGE_RESP_ERR_EN
  ,
  output logic        inst_bus_err
`endif
);

  typedef enum logic [0:0] {AR_IDLE, AR_SEND} ar_state_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  ar_state_e   state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  arsize_q, arsize_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        addr_ok;
  logic        r_counted;
  logic        r_is_err;
  logic        unused_in;

  // A beat arriving with nothing counted is a leftover from before a reset.
  assign r_counted = rvalid && rready && (cnt_q != 3'd0);

`ifdef INST_BRIDGE_RESP_ERR_EN
  assign r_is_err     = rresp[1];
  assign inst_bus_err = bus_err_q;
`else
  assign r_is_err     = 1'b0;
`endif

  assign unused_in = ^{inst_sram_wr, rid, rlast, rresp, bus_err_q};

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    data_ok_d = r_counted;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
    addr_ok   = 1'b0;
    case (state_q)
      AR_IDLE: begin
        addr_ok = inst_sram_req && (cnt_q < MAX_CNT);
        if (addr_ok) begin
          araddr_d = inst_sram_addr;
          arsize_d = inst_sram_size;
          state_d  = AR_SEND;
        end
      end
      AR_SEND: begin
        if (arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
    if (r_counted) begin
      rdata_d = r_is_err ? 32'h0 : rdata;
      if (r_is_err) bus_err_d = 1'b1;
    end
    cnt_d = cnt_q + {2'b00, addr_ok} - {2'b00, r_counted};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= AR_IDLE;
      araddr_q  <= 32'h0;
      arsize_q  <= 2'b00;
      cnt_q     <= 3'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;
  assign arid              = ARID_VAL;
  assign araddr            = araddr_q;
  assign arlen             = 8'd0;
  assign arsize            = {1'b0, arsize_q};
  assign arburst           = 2'b01;
  assign arlock            = 2'b00;
  assign arcache           = 4'd0;
  assign arprot            = 3'd0;
  assign arvalid           = (state_q == AR_SEND);
  assign rready            = 1'b1;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Scoreboard bench for inst_sram_axi_bridge: transaction-level reference model plus a randomised AXI slave.
module tb_inst_sram_axi_bridge;
  localparam int         MAX = 2;
  localparam logic [3:0] ARID = 4'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, req, wr, addr_ok, data_ok;
  logic [1:0]  size;
  logic [31:0] addr, sram_rdata;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, rresp;
  logic [3:0]  arcache;
  logic        arvalid, arready, rlast, rvalid, rready;
`ifdef INST_BRIDGE_RESP_ERR_EN
  logic        inst_bus_err;
`endif

  inst_sram_axi_bridge #(.ARID_VAL(ARID), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef INST_BRIDGE_RESP_ERR_EN
    , .inst_bus_err(inst_bus_err)
`endif
  );

  int errors = 0;
  int checks = 0;
  int ar_pct = 100, r_pct = 100, err_pct = 0;

  logic [31:0] slave_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_ovr[logic [31:0]];

  int          m_cnt = 0;
  bit          m_pend = 0, m_dok = 0, m_derr = 0, m_err = 0;
  logic [31:0] m_araddr = 0, m_last = 0;
  logic [1:0]  m_size = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // AXI slave: in-order, single beat, randomised ready/valid.
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 1;
    forever begin
      @(posedge clk); #1;
      arready = ($urandom_range(99) < ar_pct);
      if (slave_q.size() > 0 && $urandom_range(99) < r_pct) begin
        rvalid = 1;
        rdata  = data_of(slave_q[0]);
        rresp  = ($urandom_range(99) < err_pct) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 0;
        rdata  = $urandom;
        rresp  = 2'($urandom);
      end
      rid = 4'($urandom);
    end
  end

  // Monitor: compares this cycle against the model, then advances the model to the next edge.
  always @(negedge clk) begin : monitor
    bit exp_aok, acc, counted;
    logic [31:0] e;
    if (!resetn) begin
      if (rvalid && rready && slave_q.size() > 0) void'(slave_q.pop_front());
      m_cnt = 0; m_pend = 0; m_dok = 0; m_derr = 0; m_last = 0; m_err = 0;
      exp_q.delete();
    end else begin
      chk("data_ok", data_ok, m_dok);
      if (data_ok && m_dok) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_order: data_ok with no outstanding expected response at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (m_derr) e = 32'h0;
          chk("rdata", sram_rdata, e);
          m_last = e;
        end
      end else chk("rdata_hold", sram_rdata, m_last);
      exp_aok = req && !m_pend && (m_cnt < MAX);
      chk("addr_ok", addr_ok, exp_aok);
      chk("arvalid", arvalid, m_pend);
      if (m_pend) begin
        chk("araddr", araddr, m_araddr);
        chk("arsize", arsize, {1'b0, m_size});
        chk("ar_const", {arid, arlen, arburst, arlock, arcache, arprot},
            {ARID, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
      end
      chk("rready", rready, 1);
`ifdef INST_BRIDGE_RESP_ERR_EN
      chk("bus_err", inst_bus_err, m_err);
`endif
      acc     = exp_aok;
      counted = rvalid && rready && (m_cnt != 0);
      if (m_pend && arready) begin
        slave_q.push_back(m_araddr);
        m_pend = 0;
      end
      if (acc) begin
        m_pend = 1; m_araddr = addr; m_size = size;
        exp_q.push_back(data_of(addr));
      end
      if (rvalid && rready && slave_q.size() > 0) void'(slave_q.pop_front());
      m_dok = counted;
`ifdef INST_BRIDGE_RESP_ERR_EN
      m_derr = counted && rresp[1];
      if (m_derr) m_err = 1;
`else
      m_derr = 0;
`endif
      m_cnt = m_cnt + int'(acc) - int'(counted);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [1:0] s);
    bit done = 0;
    req = 1; addr = a; size = s;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (addr_ok) done = 1;
      @(posedge clk); #1;
    end
    req = 0;
    chk("fetch_accept", done, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (m_cnt == 0 && !m_pend && slave_q.size() == 0 && !m_dok) ok = 1;
      else cyc(1);
    end
    cyc(1);
    chk("drain", ok, 1);
  endtask

  task automatic wait_slave(input int n);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (slave_q.size() >= n) ok = 1;
      else cyc(1);
    end
    chk("wait_ar", ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    resetn = 0; req = 0; wr = 0; size = 0; addr = 0;
    mem_ovr[32'h1c000000] = 32'h02800c0c;
    mem_ovr[32'h1c000020] = 32'hAAAA0000;
    mem_ovr[32'h1c000024] = 32'hBBBB1111;
    mem_ovr[32'h1c000010] = 32'hDEADBEEF;
    cyc(3);
    resetn = 1;
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arsize", arsize, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rdata", sram_rdata, 0);
    @(posedge clk); #1;

    // single fetch
    fetch(32'h1c000000, 2'd2);
    drain();
    chk("single_rdata", sram_rdata, 32'h02800c0c);

    // AR backpressure, with a competing request held high
    ar_pct = 0;
    fetch(32'h1c000004, 2'd2);
    req = 1; addr = 32'h1c000008; size = 2'd1;
    cyc(5);
    req = 0; ar_pct = 100;
    drain();

    // outstanding limit
    r_pct = 0;
    fetch(32'h1c000000, 2'd2);
    fetch(32'h1c000004, 2'd2);
    req = 1; addr = 32'h1c000008; size = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("limit_addr_ok", addr_ok, 0);
      @(posedge clk); #1;
    end
    r_pct = 100;
    fetch(32'h1c000008, 2'd2);
    drain();

    // back-to-back responses
    r_pct = 0;
    fetch(32'h1c000020, 2'd2);
    fetch(32'h1c000024, 2'd2);
    wait_slave(2);
    r_pct = 100;
    drain();
    chk("b2b_last_rdata", sram_rdata, 32'hBBBB1111);

    // reset with a read in flight, stale beat must be dropped
    r_pct = 0;
    fetch(32'h1c000010, 2'd2);
    wait_slave(1);
    resetn = 0;
    cyc(1);
    resetn = 1;
    r_pct = 100;
    drain();
    chk("stale_rdata", sram_rdata, 32'h0);
    fetch(32'h1c000000, 2'd0);
    drain();
    chk("post_reset_rdata", sram_rdata, 32'h02800c0c);

`ifdef INST_BRIDGE_RESP_ERR_EN
    err_pct = 100;
    fetch(32'h1c000040, 2'd2);
    drain();
    chk("err_set", inst_bus_err, 1);
    chk("err_rdata_zero", sram_rdata, 32'h0);
    err_pct = 0;
    fetch(32'h1c000044, 2'd2);
    drain();
    chk("err_sticky", inst_bus_err, 1);
    chk("ok_rdata", sram_rdata, data_of(32'h1c000044));
    resetn = 0;
    cyc(1);
    resetn = 1;
    cyc(1);
    chk("err_cleared", inst_bus_err, 0);
    err_pct = 15;
`endif

    // randomised traffic
    ar_pct = 70; r_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      req  = ($urandom_range(99) < 60);
      addr = $urandom & 32'hFFFF_FFFC;
      size = 2'($urandom_range(2));
      cyc(1);
    end
    req = 0; ar_pct = 100; r_pct = 100;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_sram_axi_bridge.md
Name: inst_sram_axi_bridge

Overview:
Upstream neighbour of the fetch stage. Converts the fetch stage's SRAM-like instruction request interface (req/addr_ok/data_ok) into AXI4 read-address and read-data channel transactions. Single-beat reads only; responses return in order under one fixed ARID. Sits between the fetch stage's inst_sram_* ports and the CPU's AXI crossbar.

Parameters:
ARID_VAL, 4'd0, constant driven on arid
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..7)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
inst_sram_req  input  1  fetch request valid
inst_sram_wr  input  1  write flag; fetch always drives 0; block ignores it (read-only)
inst_sram_size  input  2  0=byte, 1=half, 2=word
inst_sram_addr  input  32  fetch address
inst_sram_addr_ok  output  1  request accepted this cycle
inst_sram_data_ok  output  1  one response valid this cycle
inst_sram_rdata  output  32  response data
arid  output  4  ARID_VAL
araddr  output  32  read address
arlen  output  8  constant 0
arsize  output  3  {1'b0, latched size}
arburst  output  2  constant 2'b01
arlock  output  2  constant 0
arcache  output  4  constant 0
arprot  output  3  constant 0
arvalid  output  1  address valid
arready  input  1  address accepted by slave
rid  input  4  ignored for matching
rdata  input  32  read data
rresp  input  2  read response
rlast  input  1  ignored (single beat)
rvalid  input  1  read data valid
rready  output  1  read data ready

Behaviour:
- Reset (resetn=0 at posedge): arvalid=0, araddr=0, arsize=0, inst_sram_data_ok=0, inst_sram_rdata=0, outstanding count=0, AR FSM=AR_IDLE.
- AR FSM: AR_IDLE, AR_SEND.
  - AR_IDLE: inst_sram_addr_ok = inst_sram_req && (count < MAX_OUTSTANDING), combinational.
  - On addr_ok: latch addr/size into araddr/arsize; next cycle AR_SEND with arvalid=1.
  - AR_SEND: addr_ok=0. arvalid, araddr and arsize held stable until arvalid&&arready, then AR_IDLE.
  - Minimum accept-to-accept spacing is 2 cycles.
- Outstanding count (3 bits): +1 on addr_ok, -1 on R handshake (rvalid&&rready&&count!=0). Both in the same cycle leaves the count unchanged.
- rready = 1 at all times after reset. A handshake with count==0 (stale beat after mid-operation reset) is consumed and dropped with no data_ok.
- Response: each counted R handshake yields data_ok=1 exactly one cycle later, with inst_sram_rdata = registered rdata. Back-to-back beats give consecutive data_ok pulses. Otherwise data_ok=0 and rdata holds its last value.
- Ordering: responses are returned in issue order. The fetch stage's own cancel logic discards unwanted data; the bridge never drops a counted response.
- Full boundary: count==MAX_OUTSTANDING forces addr_ok=0 even in AR_IDLE. A request may be accepted in the cycle a response frees a slot only if count < MAX before that cycle's decrement (no bypass).
- rresp is ignored when the optional feature is absent.
- Reset mid-operation: FSM, count and arvalid are cleared. In-flight AXI responses are absorbed as stale beats.

Optional Feature:
INST_BRIDGE_RESP_ERR_EN.
- Defined: adds output inst_bus_err (1 bit, reset 0). It is set sticky on any counted R handshake with rresp[1]=1 (SLVERR/DECERR) and cleared only by reset. The corresponding data_ok is still returned with rdata forced to 32'h0.
- Not defined: port absent; rresp unused; rdata passed through unchanged.

Test Plan:
- Single fetch: req=1, addr=32'h1c000000, size=2 → addr_ok same cycle; next cycle arvalid=1, araddr=1c000000, arsize=3'b010, arlen=0, arburst=01. With arready=1 then rvalid=1, rdata=32'h02800c0c → data_ok=1 one cycle after the R handshake, inst_sram_rdata=02800c0c.
- arready backpressure: arready=0 for 5 cycles → arvalid and araddr stable for 5 cycles, addr_ok=0 throughout; handshake on cycle 6 → AR_IDLE.
- Outstanding limit (MAX=2): two requests accepted (1c000000, 1c000004), no R beats → third request at 1c000008 sees addr_ok=0. One rvalid beat → count=1, addr_ok=1 next eligible cycle. Data returns in order 1c000000, 1c000004.
- Back-to-back responses: two outstanding, rvalid high 2 consecutive cycles (AAAA0000, BBBB1111) → data_ok high 2 consecutive cycles with those values in order; count returns to 0.
- Reset mid-operation: one outstanding, resetn=0 for 1 cycle, then stale rvalid with rdata=DEADBEEF → no data_ok, count stays 0, next request at 1c000000 accepted normally.
- INST_BRIDGE_RESP_ERR_EN: rresp=2'b10 on a counted beat → data_ok=1, rdata=0, inst_bus_err=1, remains 1 after a later OKAY beat; cleared only by reset.
